// File: rtl/mac_via_if.sv
// mac_via_if: CPU register bus, port pins and control lines of the VIA.
interface mac_via_if;
  logic cs, we, rd;
  logic [3:0] rs;
  logic [7:0] din, dout;
  logic [7:0] pa_in, pb_in, pa_out, pb_out, pa_ddr, pb_ddr;
  logic ca1, ca2, cb1, cb2, irq;
  modport master (
    output cs, we, rd, rs, din, pa_in, pb_in, ca1, ca2, cb1, cb2,
    input  dout, pa_out, pb_out, pa_ddr, pb_ddr, irq
  );
  modport slave (
    input  cs, we, rd, rs, din, pa_in, pb_in, ca1, ca2, cb1, cb2,
    output dout, pa_out, pb_out, pa_ddr, pb_ddr, irq
  );
endinterface

// File: rtl/mac_via.sv
// mac_via: 6522-style VIA with ports, two 16-bit timers, control-line edge flags and IFR/IER.
module mac_via #(
  parameter int C_TICK_DIV = 10,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic clk_cpu,
  input  logic reset,
  mac_via_if.slave bus
);
  localparam int DW = $clog2(C_TICK_DIV);
  logic [19:0] sync_q [C_SYNC_STAGES];
  logic [19:0] s;
  logic [7:0] pa_s, pb_s, pa_rd, pb_rd, dout_c;
  logic [4:0] cur, pol, prev_q, edge_q, edge_d;
  logic [DW-1:0] div_q, div_d;
  logic tick, irq_c, rd_s, t1_fire, t2_dec, t2_fire;
  logic [15:0] wr_en;
  logic [7:0] ora_q, ora_d, orb_q, orb_d, ddra_q, ddra_d, ddrb_q, ddrb_d;
  logic [7:0] sr_q, sr_d, acr_q, acr_d, pcr_q, pcr_d, t2l_q, t2l_d;
  logic [15:0] t1c_q, t1c_d, t1l_q, t1l_d, t2c_q, t2c_d;
  logic t1_arm_q, t1_arm_d, t2_arm_q, t2_arm_d, pb7_q, pb7_d;
  logic [6:0] ifr_q, ifr_d, ier_q, ier_d, ifr_set, ifr_clr;
  always_ff @(posedge clk_cpu) begin
    sync_q[0] <= reset ? '0 : {bus.cb2, bus.cb1, bus.ca2, bus.ca1, bus.pb_in, bus.pa_in};
    for (int k = 1; k < C_SYNC_STAGES; k++) sync_q[k] <= reset ? '0 : sync_q[k-1];
  end
  assign s = sync_q[C_SYNC_STAGES-1];
  assign pa_s = s[7:0];
  assign pb_s = s[15:8];
  // bit 4 is PB6, always counted on its falling edge
  assign cur = {pb_s[6], s[19:16]};
  assign pol = {1'b0, pcr_q[6], pcr_q[4], pcr_q[2], pcr_q[0]};
  assign edge_d = (cur & ~prev_q & pol) | (~cur & prev_q & ~pol);
  assign wr_en = (bus.cs && bus.we) ? 16'(1) << bus.rs : '0;
  assign rd_s = bus.cs && bus.rd;
  assign tick = div_q == DW'(C_TICK_DIV - 1);
  assign t1_fire = tick && t1c_q == '0 && t1_arm_q && !wr_en[5];
  assign t2_dec = acr_q[5] ? edge_q[4] : tick;
  assign t2_fire = t2_dec && t2c_q == '0 && t2_arm_q && !wr_en[9];
  assign ifr_set = {t1_fire, t2_fire, edge_q[2], edge_q[3], 1'b0, edge_q[0], edge_q[1]};
  assign ifr_clr = (wr_en[13] ? bus.din[6:0] : 7'h0)
                 | {wr_en[5] | wr_en[7] | (rd_s && bus.rs == 4'h4),
                    wr_en[9] | (rd_s && bus.rs == 4'h8), 3'b0,
                    {2{wr_en[1] | (rd_s && bus.rs == 4'h1)}}};
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    ora_d = (wr_en[1] || wr_en[15]) ? bus.din : ora_q;
    orb_d = wr_en[0] ? bus.din : orb_q;
    ddrb_d = wr_en[2] ? bus.din : ddrb_q;
    ddra_d = wr_en[3] ? bus.din : ddra_q;
    sr_d = wr_en[10] ? bus.din : sr_q;
    acr_d = wr_en[11] ? bus.din : acr_q;
    pcr_d = wr_en[12] ? bus.din : pcr_q;
    t1l_d = {(wr_en[5] || wr_en[7]) ? bus.din : t1l_q[15:8],
             (wr_en[4] || wr_en[6]) ? bus.din : t1l_q[7:0]};
    t1c_d = wr_en[5] ? {bus.din, t1l_q[7:0]} : !tick ? t1c_q
          : (t1_fire && acr_q[6]) ? t1l_q : t1c_q - 1'b1;
    t1_arm_d = wr_en[5] || (t1_arm_q && !(t1_fire && !acr_q[6]));
    pb7_d = (wr_en[5] && !acr_q[6]) ? 1'b0 : !t1_fire ? pb7_q : acr_q[6] ? ~pb7_q : 1'b1;
    t2l_d = wr_en[8] ? bus.din : t2l_q;
    t2c_d = wr_en[9] ? {bus.din, t2l_q} : t2_dec ? t2c_q - 1'b1 : t2c_q;
    t2_arm_d = wr_en[9] || (t2_arm_q && !t2_fire);
    ifr_d = (ifr_q & ~ifr_clr) | ifr_set;
    ier_d = !wr_en[14] ? ier_q : bus.din[7] ? ier_q | bus.din[6:0] : ier_q & ~bus.din[6:0];
  end
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      {prev_q, edge_q, div_q, ora_q, orb_q, ddra_q, ddrb_q, sr_q, acr_q, pcr_q} <= '0;
      {t1c_q, t1l_q, t2c_q, t2l_q, t1_arm_q, t2_arm_q, ifr_q, ier_q} <= '0;
      pb7_q <= 1'b1;
    end else begin
      prev_q <= cur;
      edge_q <= edge_d;
      div_q <= div_d;
      {ora_q, orb_q, ddra_q, ddrb_q, sr_q, acr_q, pcr_q} <= {ora_d, orb_d, ddra_d, ddrb_d, sr_d, acr_d, pcr_d};
      {t1c_q, t1l_q, t2c_q, t2l_q, t1_arm_q, t2_arm_q} <= {t1c_d, t1l_d, t2c_d, t2l_d, t1_arm_d, t2_arm_d};
      {ifr_q, ier_q, pb7_q} <= {ifr_d, ier_d, pb7_d};
    end
  end
  assign irq_c = |(ifr_q & ier_q);
  assign pa_rd = (ora_q & ddra_q) | (pa_s & ~ddra_q);
  assign pb_rd = (orb_q & ddrb_q) | (pb_s & ~ddrb_q);
  always_comb begin
    dout_c = '0;
    case (bus.rs)
      4'h0: dout_c = acr_q[7] ? {pb7_q, pb_rd[6:0]} : pb_rd;
      4'h1: dout_c = pa_rd;
      4'h2: dout_c = ddrb_q;
      4'h3: dout_c = ddra_q;
      4'h4: dout_c = t1c_q[7:0];
      4'h5: dout_c = t1c_q[15:8];
      4'h6: dout_c = t1l_q[7:0];
      4'h7: dout_c = t1l_q[15:8];
      4'h8: dout_c = t2c_q[7:0];
      4'h9: dout_c = t2c_q[15:8];
      4'hA: dout_c = sr_q;
      4'hB: dout_c = acr_q;
      4'hC: dout_c = pcr_q;
      4'hD: dout_c = {irq_c, ifr_q};
      4'hE: dout_c = {1'b1, ier_q};
      4'hF: dout_c = pa_rd;
    endcase
  end
  assign bus.dout = dout_c;
  assign bus.irq = irq_c;
  assign bus.pa_out = ora_q;
  assign bus.pb_out = acr_q[7] ? {pb7_q, orb_q[6:0]} : orb_q;
  assign bus.pa_ddr = ddra_q;
  assign bus.pb_ddr = ddrb_q;
endmodule

// File: tb/tb_mac_via.sv
// tb_mac_via: directed self-checking bench for mac_via with hand-computed expectations.
module tb_mac_via;
  localparam int DIV = 10;
  localparam int SYNC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tb_div = 0;
  int vecs = 0;
  int errs = 0;
  mac_via_if bus();
  mac_via #(.C_TICK_DIV(DIV), .C_SYNC_STAGES(SYNC)) dut (.clk_cpu(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  // tick phase: divider counts from 0 after reset, ticks when it sits at DIV-1
  always @(posedge clk) tb_div <= (rst || tb_div == DIV - 1) ? 0 : tb_div + 1;

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.rs = a; bus.din = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.rs = a;
    @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    bus.rs = a;
    #1 d = bus.dout;
  endtask

  // write whose clock edge coincides with a tick
  task automatic wr_tick(input logic [3:0] a, input logic [7:0] d);
    for (int i = 0; i < DIV && tb_div != DIV - 1; i++) @(negedge clk);
    wr(a, d);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    wr(4'h3, 8'hFF);
    wr(4'h1, 8'hEF);
    vecs++; if (bus.pa_ddr !== 8'hFF) begin errs++; $display("FAIL pre_ddra: got %h want ff", bus.pa_ddr); end
    vecs++; if (bus.pa_out !== 8'hEF) begin errs++; $display("FAIL pre_ora: got %h want ef", bus.pa_out); end
    do_reset();
    vecs++; if (bus.pa_ddr !== 8'h00) begin errs++; $display("FAIL rst_ddra: got %h want 00", bus.pa_ddr); end
    vecs++; if (bus.pa_out !== 8'h00) begin errs++; $display("FAIL rst_ora: got %h want 00", bus.pa_out); end
    vecs++; if (bus.pb_out !== 8'h00) begin errs++; $display("FAIL rst_orb: got %h want 00", bus.pb_out); end
    vecs++; if (bus.pb_ddr !== 8'h00) begin errs++; $display("FAIL rst_ddrb: got %h want 00", bus.pb_ddr); end
    vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL rst_irq: got %b want 0", bus.irq); end
    peek(4'hE, d);
    vecs++; if (d !== 8'h80) begin errs++; $display("FAIL rst_ier: got %h want 80", d); end
  endtask

  task automatic test_t1_oneshot;
    logic [7:0] d;
    wr(4'hE, 8'hC0);
    wr(4'hB, 8'h00);
    wr(4'h6, 8'h05);
    wr_tick(4'h5, 8'h00);
    repeat (6 * DIV - 1) @(negedge clk);
    vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL t1_early: irq=%b want 0", bus.irq); end
    @(negedge clk);
    vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL t1_fire: irq=%b want 1", bus.irq); end
    peek(4'hD, d);
    vecs++; if (d !== 8'hC0) begin errs++; $display("FAIL t1_ifr: got %h want c0", d); end
    rd(4'h4);
    vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL t1_rd_clear: irq=%b want 0", bus.irq); end
    repeat (20 * DIV) @(negedge clk);
    peek(4'hD, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL t1_no_second: ifr=%h want 00", d); end
  endtask

  task automatic test_t1_freerun;
    wr(4'hB, 8'hC0);
    wr(4'h6, 8'h03);
    wr_tick(4'h5, 8'h00);
    vecs++; if (bus.pb_out[7] !== 1'b1) begin errs++; $display("FAIL fr_pb7_init: got %b want 1", bus.pb_out[7]); end
    repeat (4 * DIV - 1) @(negedge clk);
    vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL fr_early: irq=%b want 0", bus.irq); end
    @(negedge clk);
    vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL fr_fire1: irq=%b want 1", bus.irq); end
    vecs++; if (bus.pb_out[7] !== 1'b0) begin errs++; $display("FAIL fr_pb7_a: got %b want 0", bus.pb_out[7]); end
    wr(4'hD, 8'h40);
    vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL fr_clear: irq=%b want 0", bus.irq); end
    repeat (4 * DIV - 2) @(negedge clk);
    vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL fr_between: irq=%b want 0", bus.irq); end
    @(negedge clk);
    vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL fr_fire2: irq=%b want 1", bus.irq); end
    vecs++; if (bus.pb_out[7] !== 1'b1) begin errs++; $display("FAIL fr_pb7_b: got %b want 1", bus.pb_out[7]); end
  endtask

  task automatic test_set_wins;
    logic [7:0] d;
    repeat (4 * DIV - 1) @(negedge clk);
    wr(4'hD, 8'h40);
    vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL set_wins_irq: irq=%b want 1", bus.irq); end
    peek(4'hD, d);
    vecs++; if (d !== 8'hC0) begin errs++; $display("FAIL set_wins_ifr: got %h want c0", d); end
    wr(4'hD, 8'h40);
    vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL set_wins_later_clear: irq=%b want 0", bus.irq); end
  endtask

  task automatic test_ctrl_edges;
    logic [7:0] d;
    wr(4'hC, 8'h01);
    wr(4'hE, 8'h82);
    bus.ca1 = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL ca1_rise_irq: irq=%b want 1", bus.irq); end
    peek(4'hD, d);
    vecs++; if (d !== 8'h82) begin errs++; $display("FAIL ca1_rise_ifr: got %h want 82", d); end
    rd(4'hF);
    peek(4'hD, d);
    vecs++; if (d !== 8'h82) begin errs++; $display("FAIL ca1_rdF_keeps: got %h want 82", d); end
    rd(4'h1);
    peek(4'hD, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL ca1_rd1_clears: got %h want 00", d); end
    bus.ca1 = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    peek(4'hD, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL ca1_fall_ignored: got %h want 00", d); end
    bus.cb2 = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    peek(4'hD, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL cb2_rise_ignored: got %h want 00", d); end
    bus.cb2 = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    peek(4'hD, d);
    vecs++; if (d !== 8'h08) begin errs++; $display("FAIL cb2_fall_masked: got %h want 08", d); end
    wr(4'hD, 8'h7F);
    peek(4'hD, d);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL ifr_clear_all: got %h want 00", d); end
  endtask

  task automatic test_port_read;
    logic [7:0] d;
    wr(4'h3, 8'h0F);
    wr(4'hF, 8'hA5);
    bus.pa_in = 8'h3C;
    repeat (SYNC + 1) @(negedge clk);
    peek(4'hF, d);
    vecs++; if (d !== 8'h35) begin errs++; $display("FAIL pa_mixed_read: got %h want 35", d); end
  endtask

  task automatic test_t2_count;
    logic [7:0] d;
    wr(4'hB, 8'h20);
    bus.pb_in = 8'hFF;
    repeat (SYNC + 3) @(negedge clk);
    wr(4'h8, 8'h02);
    wr(4'h9, 8'h00);
    repeat (5 * DIV) @(negedge clk);
    peek(4'h8, d);
    vecs++; if (d !== 8'h02) begin errs++; $display("FAIL t2_no_tick: got %h want 02", d); end
    for (int k = 0; k < 3; k++) begin
      bus.pb_in[6] = 1'b0;
      repeat (SYNC + 3) @(negedge clk);
      peek(4'hD, d);
      vecs++; if (d !== (k == 2 ? 8'h20 : 8'h00)) begin errs++; $display("FAIL t2_edge%0d: ifr=%h want %h", k + 1, d, k == 2 ? 8'h20 : 8'h00); end
      bus.pb_in[6] = 1'b1;
      repeat (SYNC + 3) @(negedge clk);
    end
    peek(4'h9, d);
    vecs++; if (d !== 8'hFF) begin errs++; $display("FAIL t2_wrap: got %h want ff", d); end
  endtask

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.rd = 1'b0; bus.rs = 4'h0; bus.din = 8'h00;
    bus.pa_in = 8'h00; bus.pb_in = 8'h00;
    bus.ca1 = 1'b0; bus.ca2 = 1'b0; bus.cb1 = 1'b0; bus.cb2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_t1_oneshot();
    test_t1_freerun();
    test_set_wins();
    do_reset();
    test_ctrl_edges();
    test_port_read();
    test_t2_count();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
